stereo_frame_writer: RTL and testbench



---
 rtl/stereo_frame_writer_if.sv | 21 ++
 rtl/stereo_frame_writer.sv | 167 ++++++++++++++++
 tb/tb_stereo_frame_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stereo_frame_writer_if.sv
// Lockstep left/right pixel stream into the stereo frame writer.
// A pair transfers on a clock edge where pix_valid_in and pix_ready_out are both 1.
interface stereo_frame_writer_if #(
  parameter int PIX_W = 6
);
  logic             pix_valid_in;
  logic             pix_ready_out;
  logic             sof_in;
  logic [PIX_W-1:0] left_pix_in;
  logic [PIX_W-1:0] right_pix_in;

  modport master (
    output pix_valid_in, sof_in, left_pix_in, right_pix_in,
    input  pix_ready_out
  );

  modport slave (
    input  pix_valid_in, sof_in, left_pix_in, right_pix_in,
    output pix_ready_out
  );
endinterface

// File: rtl/stereo_frame_writer.sv
// Packs a lockstep stereo pixel stream into BRAM words and writes them row-major.
// Optional macro FRAME_CHECKSUM_EN adds per-frame XOR checksums of the written words.
module stereo_frame_writer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 320,
  parameter int PIX_W  = 6,
  parameter int WORD_W = 48,
  parameter int ADDR_W = $clog2(IMG_H * (IMG_W / (WORD_W / PIX_W)))
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  stereo_frame_writer_if.slave pix_if,
  output logic [ADDR_W-1:0] addr_out,
  output logic [WORD_W-1:0] left_din_out,
  output logic [WORD_W-1:0] right_din_out,
  output logic              we_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              sof_err_out,
  output logic [1:0]        state_dbg_out
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] left_csum_out,
  output logic [WORD_W-1:0] right_csum_out
`endif
);
  localparam int PPW     = WORD_W / PIX_W;
  localparam int WPR     = IMG_W / PPW;
  localparam int PIX_CW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int WORD_CW = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int ROW_CW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PACK = 2'd1, S_DONE = 2'd2} state_t;

  state_t              r_state;
  logic [PIX_CW-1:0]   r_pix_idx;
  logic [WORD_CW-1:0]  r_word;
  logic [ROW_CW-1:0]   r_row;
  logic [WORD_W-1:0]   r_left_acc, r_right_acc;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_left_din, r_right_din;
  logic                r_we, r_ready, r_busy, r_done, r_sof_err;

  logic                w_accept, w_start, w_take, w_full, w_last_word;
  logic [PIX_CW-1:0]   w_slot;
  logic [WORD_CW-1:0]  w_word;
  logic [ROW_CW-1:0]   w_row;
  logic [ADDR_W-1:0]   w_addr;
  logic [WORD_W-1:0]   w_left_word, w_right_word;
  int                  w_lsb;

  // A sof pixel restarts position counters in the same cycle it is stored.
  assign w_accept    = pix_if.pix_valid_in & r_ready;
  assign w_start     = w_accept & pix_if.sof_in;
  assign w_take      = w_accept & (pix_if.sof_in | (r_state == S_PACK));
  assign w_slot      = w_start ? '0 : r_pix_idx;
  assign w_word      = w_start ? '0 : r_word;
  assign w_row       = w_start ? '0 : r_row;
  assign w_full      = w_take & (w_slot == PIX_CW'(PPW - 1));
  assign w_last_word = (w_word == WORD_CW'(WPR - 1)) & (w_row == ROW_CW'(IMG_H - 1));
  assign w_addr      = ADDR_W'(w_row) * ADDR_W'(WPR) + ADDR_W'(w_word);

  always_comb begin
    w_lsb        = int'(w_slot) * PIX_W;
    w_left_word  = w_start ? '0 : r_left_acc;
    w_right_word = w_start ? '0 : r_right_acc;
    w_left_word[w_lsb +: PIX_W]  = pix_if.left_pix_in;
    w_right_word[w_lsb +: PIX_W] = pix_if.right_pix_in;
  end

`ifdef FRAME_CHECKSUM_EN
  logic [WORD_W-1:0] r_left_csum, r_right_csum;
  assign left_csum_out  = r_left_csum;
  assign right_csum_out = r_right_csum;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state     <= S_IDLE;
      r_pix_idx   <= '0;
      r_word      <= '0;
      r_row       <= '0;
      r_left_acc  <= '0;
      r_right_acc <= '0;
      r_addr      <= '0;
      r_left_din  <= '0;
      r_right_din <= '0;
      r_we        <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sof_err   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_left_csum  <= '0;
      r_right_csum <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_PACK: begin
          r_ready <= 1'b1;
          if ((w_accept & ~w_take) | (w_start & (r_state == S_PACK)))
            r_sof_err <= 1'b1;
          if (w_take) begin
            r_left_acc  <= w_left_word;
            r_right_acc <= w_right_word;
            if (w_full) begin
              r_we        <= 1'b1;
              r_addr      <= w_addr;
              r_left_din  <= w_left_word;
              r_right_din <= w_right_word;
              r_pix_idx   <= '0;
              if (w_word == WORD_CW'(WPR - 1)) begin
                r_word <= '0;
                r_row  <= w_last_word ? '0 : w_row + 1'b1;
              end else begin
                r_word <= w_word + 1'b1;
                r_row  <= w_row;
              end
              if (w_last_word) begin
                r_state <= S_DONE;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_PACK;
                r_busy  <= 1'b1;
              end
            end else begin
              r_pix_idx <= w_slot + 1'b1;
              r_word    <= w_word;
              r_row     <= w_row;
              r_state   <= S_PACK;
              r_busy    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef FRAME_CHECKSUM_EN
      // Restart on sof; a word completed by the sof pixel itself still counts.
      if (w_full) begin
        r_left_csum  <= (w_start ? '0 : r_left_csum) ^ w_left_word;
        r_right_csum <= (w_start ? '0 : r_right_csum) ^ w_right_word;
      end else if (w_start) begin
        r_left_csum  <= '0;
        r_right_csum <= '0;
      end
`endif
    end
  end

  assign pix_if.pix_ready_out = r_ready;
  assign addr_out       = r_addr;
  assign left_din_out   = r_left_din;
  assign right_din_out  = r_right_din;
  assign we_out         = r_we;
  assign busy_out       = r_busy;
  assign frame_done_out = r_done;
  assign sof_err_out    = r_sof_err;
  assign state_dbg_out  = r_state;
endmodule

// File: tb/tb_stereo_frame_writer.sv
// Randomized bench for stereo_frame_writer on a reduced 32x4 frame, checked against
// a pixel-list reference model that predicts every output each cycle.
module tb_stereo_frame_writer;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 4;
  localparam int PIX_W  = 6;
  localparam int WORD_W = 48;
  localparam int PPW    = WORD_W / PIX_W;
  localparam int TOTAL_WORDS = IMG_H * IMG_W / PPW;
  localparam int TOTAL_PIX   = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(TOTAL_WORDS);
  localparam int EW     = ADDR_W + 2 * WORD_W;

  logic              clk;
  logic              rst_n_in;
  logic [ADDR_W-1:0] addr_out;
  logic [WORD_W-1:0] left_din_out, right_din_out;
  logic              we_out, busy_out, frame_done_out, sof_err_out;
  logic [1:0]        state_dbg;
`ifdef FRAME_CHECKSUM_EN
  logic [WORD_W-1:0] left_csum_out, right_csum_out;
`endif

  stereo_frame_writer_if #(.PIX_W(PIX_W)) pix_if ();

  stereo_frame_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n_in),
    .pix_if         (pix_if),
    .addr_out       (addr_out),
    .left_din_out   (left_din_out),
    .right_din_out  (right_din_out),
    .we_out         (we_out),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .sof_err_out    (sof_err_out),
    .state_dbg_out  (state_dbg)
`ifdef FRAME_CHECKSUM_EN
    ,
    .left_csum_out  (left_csum_out),
    .right_csum_out (right_csum_out)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_we   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: frame position is a plain word count, pixels wait in lists
  logic [PIX_W-1:0]  lbuf[$], rbuf[$];
  logic [EW-1:0]     exp_q[$];
  bit                m_in_frame, m_err, m_ready, m_busy, m_done, m_done_next, m_we;
  int                m_wcnt;
  logic [ADDR_W-1:0] h_addr;
  logic [WORD_W-1:0] h_l, h_r, m_lcs, m_rcs;

  task automatic model_step(input bit rst_n, input bit v, input bit s,
                            input logic [PIX_W-1:0] l, input logic [PIX_W-1:0] r);
    bit acc, last;
    logic [WORD_W-1:0] lw, rw;
    m_we = 0;
    if (!rst_n) begin
      lbuf.delete(); rbuf.delete(); exp_q.delete();
      m_in_frame = 0; m_err = 0; m_ready = 0; m_busy = 0; m_done = 0; m_done_next = 0;
      m_wcnt = 0; h_addr = '0; h_l = '0; h_r = '0; m_lcs = '0; m_rcs = '0;
      return;
    end
    m_done = m_done_next;
    m_done_next = 0;
    acc  = v && m_ready;
    last = 0;
    if (acc) begin
      if (s) begin
        if (m_in_frame) m_err = 1;
        lbuf.delete(); rbuf.delete();
        m_in_frame = 1; m_wcnt = 0; m_lcs = '0; m_rcs = '0;
        lbuf.push_back(l); rbuf.push_back(r);
      end else if (m_in_frame) begin
        lbuf.push_back(l); rbuf.push_back(r);
      end else begin
        m_err = 1;
      end
    end
    if (lbuf.size() == PPW) begin
      lw = '0; rw = '0;
      for (int k = 0; k < PPW; k++) begin
        lw = lw | (WORD_W'(lbuf[k]) << (k * PIX_W));
        rw = rw | (WORD_W'(rbuf[k]) << (k * PIX_W));
      end
      exp_q.push_back({ADDR_W'(m_wcnt), lw, rw});
      m_lcs = m_lcs ^ lw; m_rcs = m_rcs ^ rw;
      lbuf.delete(); rbuf.delete();
      m_we = 1;
      m_wcnt++;
      if (m_wcnt == TOTAL_WORDS) begin
        m_in_frame = 0; last = 1; m_done_next = 1;
      end
    end
    m_ready = !last;
    m_busy  = m_in_frame;
  endtask

  // scoreboard: compare every output each cycle, away from the rising edge
  task automatic check_outputs();
    logic [EW-1:0] e;
    if (m_we && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {h_addr, h_l, h_r} = e;
    end
    if (we_out) n_we++;
    chk("ready", pix_if.pix_ready_out, m_ready);
    chk("busy", busy_out, m_busy);
    chk("frame_done", frame_done_out, m_done);
    chk("sof_err", sof_err_out, m_err);
    chk("we", we_out, m_we);
    chk("addr", addr_out, h_addr);
    chk("left_din", left_din_out, h_l);
    chk("right_din", right_din_out, h_r);
`ifdef FRAME_CHECKSUM_EN
    if (m_done) begin
      chk("left_csum", left_csum_out, m_lcs);
      chk("right_csum", right_csum_out, m_rcs);
    end
`endif
  endtask

  // driver
  task automatic cycle(input bit rst_n, input bit v, input bit s,
                       input logic [PIX_W-1:0] l, input logic [PIX_W-1:0] r);
    rst_n_in = rst_n;
    pix_if.pix_valid_in = v;
    pix_if.sof_in       = s;
    pix_if.left_pix_in  = l;
    pix_if.right_pix_in = r;
    @(posedge clk);
    model_step(rst_n, v, s, l, r);
    @(negedge clk);
    check_outputs();
  endtask

  // mode: 0 ramp k%64 / 63-k%64, 1 random, 2 all ones, 3 only pixel 0 = 1
  task automatic send(input int n, input int gap, input bit sof_first,
                      input int sof_pct, input int mode);
    for (int k = 0; k < n; k++) begin
      int g, tries;
      bit s, acc;
      logic [PIX_W-1:0] l, r;
      g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
      repeat (g) cycle(1, 0, 0, '0, '0);
      case (mode)
        0: begin l = PIX_W'(k % 64); r = PIX_W'(63 - (k % 64)); end
        1: begin l = PIX_W'($urandom); r = PIX_W'($urandom); end
        2: begin l = PIX_W'(1); r = PIX_W'(1); end
        default: begin l = PIX_W'(k == 0); r = PIX_W'(k == 0); end
      endcase
      s = (k == 0) ? sof_first : (int'($urandom_range(0, 99)) < sof_pct);
      tries = 0;
      do begin
        acc = m_ready;
        cycle(1, 1, s, l, r);
        tries++;
      end while (!acc && tries < 4);
      if (!acc) chk("accept_timeout", 1'b0, 1'b1);
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(0, 0, 0, '0, '0);
  endtask

  initial begin
    rst_n_in = 1'b0;
    pix_if.pix_valid_in = 1'b0;
    pix_if.sof_in       = 1'b0;
    pix_if.left_pix_in  = '0;
    pix_if.right_pix_in = '0;
    do_reset(2);
    repeat (2) cycle(1, 0, 0, '0, '0);

    // continuous full frame, ramp pattern
    n_we = 0;
    send(TOTAL_PIX, 0, 1, 0, 0);
    repeat (3) cycle(1, 0, 0, '0, '0);
    chk("full_frame_writes", n_we, TOTAL_WORDS);

    // one row with valid every third cycle
    n_we = 0;
    send(IMG_W, 2, 1, 0, 0);
    repeat (2) cycle(1, 0, 0, '0, '0);
    chk("gap_row_writes", n_we, IMG_W / PPW);
    do_reset(1);

    // data before sof, then a clean frame
    n_we = 0;
    send(5, 0, 0, 0, 0);
    chk("pre_sof_writes", n_we, 0);
    chk("pre_sof_err", sof_err_out, 1'b1);
    send(TOTAL_PIX, 0, 1, 0, 1);
    repeat (3) cycle(1, 0, 0, '0, '0);
    chk("pre_sof_frame_writes", n_we, TOTAL_WORDS);
    do_reset(1);

    // sof arriving mid-frame with 5 pixels pending
    n_we = 0;
    send(13, 0, 1, 0, 0);
    send(TOTAL_PIX, 0, 1, 0, 1);
    repeat (3) cycle(1, 0, 0, '0, '0);
    chk("mid_sof_err", sof_err_out, 1'b1);
    chk("mid_sof_writes", n_we, 1 + TOTAL_WORDS);
    do_reset(1);

    // reset mid-frame, then a clean frame
    send(50, 0, 1, 0, 1);
    do_reset(1);
    n_we = 0;
    send(TOTAL_PIX, -1, 1, 0, 1);
    repeat (3) cycle(1, 0, 0, '0, '0);
    chk("post_reset_writes", n_we, TOTAL_WORDS);
    chk("post_reset_err", sof_err_out, 1'b0);

    // random traffic with occasional stray sof
    for (int i = 0; i < 4; i++) begin
      send(TOTAL_PIX, -1, 1, 1, 1);
      repeat (int'($urandom_range(1, 4))) cycle(1, 0, 0, '0, '0);
    end
    do_reset(1);

`ifdef FRAME_CHECKSUM_EN
    send(TOTAL_PIX, 0, 1, 0, 2);
    repeat (3) cycle(1, 0, 0, '0, '0);
    chk("csum_all_ones", left_csum_out, '0);
    send(TOTAL_PIX, 0, 1, 0, 3);
    repeat (3) cycle(1, 0, 0, '0, '0);
    chk("csum_word0", left_csum_out, 48'h000000_000001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
